// File: rtl/instr_stream_encoder_pkg.sv
// Shared opcode/funct constants, request kinds and encoder state.
// Also imported by the controller's decoder.
package instr_stream_encoder_pkg;

  typedef enum logic [3:0] {
    K_NOP  = 4'd0,
    K_ADDU = 4'd1,
    K_SUBU = 4'd2,
    K_ORI  = 4'd3,
    K_LW   = 4'd4,
    K_SW   = 4'd5,
    K_BEQ  = 4'd6,
    K_LUI  = 4'd7,
    K_JAL  = 4'd8,
    K_JR   = 4'd9,
    K_LI   = 4'd10
  } kind_e;

  typedef enum logic {
    S_IDLE,
    S_LI_LO
  } state_e;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_JAL     = 6'b000011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  function automatic logic [31:0] r_word(
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic [4:0] rd,
    input logic [5:0] fn
  );
    return {OP_SPECIAL, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_word(
    input logic [5:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [15:0] imm
  );
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational word builder: packs fields for one request kind
// and flags requests that cannot be encoded at the given PC.
module instr_field_pack
  import instr_stream_encoder_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [31:0] imm,
  input  logic [29:0] pcw,
  output logic [31:0] word,
  output logic [31:0] lo_word,
  output logic        two,
  output logic        ok
);

  logic [29:0] npcw;
  logic [29:0] dw;
  logic        aligned;
  logic        off_ok;
  logic        seg_ok;

  // Word-granular arithmetic: offset = target/4 - (PC+4)/4.
  assign npcw    = pcw + 30'd1;
  assign dw      = imm[31:2] - npcw;
  assign aligned = (imm[1:0] == 2'b00);
  assign off_ok  = (dw[29:15] == '0) || (dw[29:15] == '1);
  assign seg_ok  = (imm[31:28] == npcw[29:26]);

  always_comb begin
    word    = '0;
    lo_word = i_word(OP_ORI, rt, rt, imm[15:0]);
    two     = 1'b0;
    ok      = 1'b1;
    case (kind)
      K_NOP:  word = '0;
      K_ADDU: word = r_word(rs, rt, rd, FN_ADDU);
      K_SUBU: word = r_word(rs, rt, rd, FN_SUBU);
      K_JR:   word = r_word(rs, 5'd0, 5'd0, FN_JR);
      K_ORI:  word = i_word(OP_ORI, rs, rt, imm[15:0]);
      K_LW:   word = i_word(OP_LW, rs, rt, imm[15:0]);
      K_SW:   word = i_word(OP_SW, rs, rt, imm[15:0]);
      K_LUI:  word = i_word(OP_LUI, 5'd0, rt, imm[15:0]);
      K_BEQ: begin
        word = i_word(OP_BEQ, rs, rt, dw[15:0]);
        ok   = aligned && off_ok;
      end
      K_JAL: begin
        word = {OP_JAL, imm[27:2]};
        ok   = aligned && seg_ok;
      end
      K_LI: begin
        if (imm[31:16] == 16'd0) begin
          word = i_word(OP_ORI, 5'd0, rt, imm[15:0]);
        end else begin
          word = i_word(OP_LUI, 5'd0, rt, imm[31:16]);
          two  = (imm[15:0] != 16'd0);
        end
      end
      default: ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// Encodes symbolic requests into MIPS words and streams them into
// instruction memory from BASE_PC upward; LI may take two words.
module instr_stream_encoder
  import instr_stream_encoder_pkg::*;
#(
  parameter int          ADDR_W  = 10,
  parameter logic [31:0] BASE_PC = 32'h0000_3000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_kind,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [31:0]       req_imm,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_e      state, next_state;
  logic [29:0] pcw;
  logic [31:0] word, lo_word, pend;
  logic        two, ok;
  logic        fire, reject, accept;

  assign pcw  = BASE_PC[31:2] + 30'(count);
  assign full = (count == CAP);

  instr_field_pack u_pack (
    .kind    (req_kind),
    .rs      (req_rs),
    .rt      (req_rt),
    .rd      (req_rd),
    .imm     (req_imm),
    .pcw     (pcw),
    .word    (word),
    .lo_word (lo_word),
    .two     (two),
    .ok      (ok)
  );

  always_comb begin
    next_state = state;
    req_ready  = (state == S_IDLE);
    fire       = req_valid && req_ready;
    // A two-word LI needs both slots free or nothing is written.
    reject     = fire && (!ok || full || (two && count == CAP - ONE));
    accept     = fire && !reject;
    if (state == S_LI_LO) begin
      next_state = S_IDLE;
    end else if (accept && two) begin
      next_state = S_LI_LO;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
      count    <= '0;
      err      <= 1'b0;
      pend     <= '0;
    end else begin
      im_we <= 1'b0;
      if (state == S_LI_LO) begin
        im_we    <= 1'b1;
        im_addr  <= count[ADDR_W-1:0];
        im_wdata <= pend;
        count    <= count + ONE;
      end else if (accept) begin
        im_we    <= 1'b1;
        im_addr  <= count[ADDR_W-1:0];
        im_wdata <= word;
        count    <= count + ONE;
        pend     <= lo_word;
      end
      if (reject) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/instr_stream_encoder.md
Name: instr_stream_encoder

Overview:
- Encoder side of the P4 instruction decode path: turns symbolic instruction requests into MIPS machine words and writes them sequentially into instruction memory (IM) starting at the base PC.
- Used by the self-test bench and the boot loader, so control-path programs are produced in hardware instead of hand-written hex.
- Covers the same instruction subset the controller decodes, plus the LI pseudo-instruction, which expands to LUI/ORI.

Parameters:
- ADDR_W, 10, IM word-address width; capacity 2^ADDR_W words.
- BASE_PC, 32'h00003000, byte PC of IM word 0.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-low reset (reset==0 at a posedge clears all state).
- req_valid  in  1  request present.
- req_ready  out  1  encoder can accept a request this cycle.
- req_kind  in  4  0 NOP, 1 ADDU, 2 SUBU, 3 ORI, 4 LW, 5 SW, 6 BEQ, 7 LUI, 8 JAL, 9 JR, 10 LI; 11-15 illegal.
- req_rs, req_rt, req_rd  in  5 each  register fields.
- req_imm  in  32  ORI/LW/SW/LUI use [15:0]; BEQ/JAL take an absolute byte target; LI takes a full 32-bit constant.
- im_we  out  1  IM write strobe.
- im_addr  out  ADDR_W  IM word address.
- im_wdata  out  32  encoded word.
- count  out  ADDR_W+1  words written so far.
- full  out  1  count == 2^ADDR_W.
- err  out  1  sticky error flag.

Behaviour:
- Reset: im_we=0, im_addr=0, im_wdata=0, count=0, full=0, err=0, state=IDLE, req_ready=1.
- Handshake: a request transfers at a posedge with req_valid&&req_ready. Request inputs are sampled only at transfer.
- Latency: the encoded word appears on im_we/im_addr/im_wdata in the cycle after the transfer (registered outputs). im_we is a 1-cycle pulse per word.
- Current PC = BASE_PC + 4*count.
- Encodings (op|rs|rt|rd|shamt|funct):
  - ADDU = 0|rs|rt|rd|0|100001
  - SUBU = 0|rs|rt|rd|0|100011
  - JR = 0|rs|0|0|0|001000
  - NOP = 32'h0
  - ORI = 001101|rs|rt|imm16
  - LW = 100011|rs|rt|imm16
  - SW = 101011|rs|rt|imm16
  - LUI = 001111|0|rt|imm16
  - BEQ = 000100|rs|rt|off16, with off = (target - (PC+4)) >>> 2
  - JAL = 000011|target[27:2]
- LI rt, K:
  - K[31:16]==0: emit one word, ORI rt,$0,K[15:0].
  - else K[15:0]==0: emit one word, LUI rt,K[31:16].
  - else: emit two words, LUI rt,K[31:16] then ORI rt,rt,K[15:0].
- FSM:
  - IDLE: req_ready=1. On a two-word LI, go to LI_LO.
  - LI_LO: req_ready=0. Emit the ORI word at the next address, then return to IDLE.
- Errors: the request is dropped (no write, count unchanged), err is set and stays 1 until reset, and the encoder keeps accepting requests. An error is raised for any of:
  - illegal kind;
  - BEQ/JAL target[1:0] != 0;
  - BEQ offset outside signed 16 bits;
  - JAL target[31:28] != (PC+4)[31:28];
  - request while full;
  - two-word LI with only one free slot (neither word is written).
- Wrap-around: count saturates at 2^ADDR_W and never wraps; im_addr holds its last value when full.
- Reset in LI_LO: the pending ORI is discarded and all state clears.
- req_valid while req_ready=0: ignored, not queued.

Decomposition:
- Shared package/header (also used by the controller): opcode and funct constants (ADDU 100001, SUBU 100011, ORI 001101, LW 100011, SW 101011, BEQ 000100, LUI 001111, JAL 000011, JR 001000), plus the req_kind encodings.
- One combinational sub-module, instr_field_pack: builds the word from kind/fields/PC and outputs a legality flag, including the BEQ/JAL target arithmetic.
- FSM, counter and output registers stay in the top module.

Test Plan:
- ADDU rs=1,rt=2,rd=3 at reset state -> next cycle im_we=1, im_addr=0, im_wdata=0x00221821, count=1.
- ORI rs=0,rt=1,imm=0x1234, then JR rs=31 -> 0x34011234 @0, 0x03E00008 @1.
- LI rt=8,K=0x12345678 -> req_ready low for one cycle; 0x3C081234 @0, 0x35085678 @1. LI K=0x00005678 -> single word 0x34085678.
- BEQ rs=1,rt=2,target=0x3000 at count 0 -> 0x1022FFFF. JAL target=0x3010 -> 0x0C000C04. JAL target=0x3012 -> err=1, no write.
- ADDR_W=2: 4 NOPs -> full=1, count=4; 5th request -> err=1, no im_we. With 3 words written, two-word LI -> err=1, count stays 3.
- Reset low while in LI_LO -> no second write; outputs, count and err all 0 on the next cycle.
